// File: rtl/spi_rx_deser_if.sv
// Received-word handshake between the SPI deserializer and its consumer.
// The master drives data and status pulses; the slave returns rx_rdy.
`timescale 1ns/1ps
interface spi_rx_deser_if #(
  parameter int SPI_RX_WIDTH = 32
);
  logic [SPI_RX_WIDTH-1:0] rx_data;
  logic                    rx_vld;
  logic                    rx_rdy;
  logic                    rx_eot;
  logic                    rx_ovf;
  logic                    rx_err;

  modport master (output rx_data, rx_vld, rx_eot, rx_ovf, rx_err, input rx_rdy);
  modport slave  (input rx_data, rx_vld, rx_eot, rx_ovf, rx_err, output rx_rdy);
endinterface

// File: rtl/spi_rx_deser.sv
// SPI receive deserializer: oversamples the SPI pins in the clk_r domain,
// shifts MSB-first frames and offers right-aligned words on a valid/ready port.
`timescale 1ns/1ps
module spi_rx_deser #(
  parameter int DLY          = 1,
  parameter int SPI_RX_WIDTH = 32,
  parameter int LEN_W        = $clog2(SPI_RX_WIDTH)
) (
  input  logic             clk_r,
  input  logic             rstn_r,
  input  logic             cpol,
  input  logic             cpoa,
  input  logic [LEN_W-1:0] length,
  input  logic             spi_bus_clk,
  input  logic             sdi,
  input  logic             cs_n,
  spi_rx_deser_if.master   rx
);

  localparam int               W       = SPI_RX_WIDTH;
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(W - 1);

  if (W < 4 || (W & (W - 1)) != 0 || DLY < 0) begin : g_bad_cfg
    $error("spi_rx_deser: SPI_RX_WIDTH must be a power of two >= 4");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic sck_s1, sck_s2, sck_s3;
  logic sdi_s1, sdi_s2;
  logic cs_s1, cs_s2;

  logic             pol_q, pha_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] bit_cnt_q;
  logic [W-1:0]     shreg_q;

  logic             latch_cfg, shift_en, frame_done, frame_abort, clear;
  logic             sck_rise, sck_fall, sample_edge;
  logic [W-1:0]     shifted, len_mask;
  logic             load, drop;

  logic [W-1:0]     rx_data_q;
  logic             rx_vld_q, rx_eot_q, rx_ovf_q, rx_err_q;

  // Frame select idles high so a reset never looks like a frame start.
  always_ff @(posedge clk_r or posedge rstn_r) begin
    if (rstn_r) begin
      sck_s1 <= 1'b0;
      sck_s2 <= 1'b0;
      sck_s3 <= 1'b0;
      sdi_s1 <= 1'b0;
      sdi_s2 <= 1'b0;
      cs_s1  <= 1'b1;
      cs_s2  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every stage take its neighbour's
      // pre-edge value, so the chain advances exactly one stage per clock.
      sck_s1 <= spi_bus_clk;
      sck_s2 <= sck_s1;
      sck_s3 <= sck_s2;
      sdi_s1 <= sdi;
      sdi_s2 <= sdi_s1;
      cs_s1  <= cs_n;
      cs_s2  <= cs_s1;
    end
  end

  assign sck_rise    = sck_s2 & ~sck_s3;
  assign sck_fall    = ~sck_s2 & sck_s3;
  assign sample_edge = (pol_q ^ pha_q) ? sck_fall : sck_rise;
  assign shifted     = {shreg_q[W-2:0], sdi_s2};
  assign len_mask    = {W{1'b1}} >> (LEN_MAX - len_q);

  always_ff @(posedge clk_r or posedge rstn_r) begin
    if (rstn_r) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!cs_s2) state_d = SHIFT;
      SHIFT:   if (cs_s2)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    // NOTE: every output gets a default first, so no branch can leave one
    // unassigned and infer a latch.
    latch_cfg   = 1'b0;
    shift_en    = 1'b0;
    frame_done  = 1'b0;
    frame_abort = 1'b0;
    clear       = 1'b0;
    case (state_q)
      IDLE: begin
        clear     = 1'b1;
        latch_cfg = !cs_s2;
      end
      SHIFT: begin
        if (cs_s2) begin
          clear       = 1'b1;
          frame_abort = (bit_cnt_q != '0);
        end else if (sample_edge) begin
          if (bit_cnt_q == len_q) begin
            frame_done = 1'b1;
            clear      = 1'b1;
          end else begin
            shift_en = 1'b1;
          end
        end
      end
      default: clear = 1'b1;
    endcase
  end

  // Mode and length are frozen for the whole frame at the IDLE->SHIFT step.
  always_ff @(posedge clk_r or posedge rstn_r) begin
    if (rstn_r) begin
      pol_q     <= 1'b0;
      pha_q     <= 1'b0;
      len_q     <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
    end else begin
      if (latch_cfg) begin
        pol_q <= cpol;
        pha_q <= cpoa;
        len_q <= length;
      end
      if (clear) begin
        bit_cnt_q <= '0;
        shreg_q   <= '0;
      end else if (shift_en) begin
        bit_cnt_q <= bit_cnt_q + 1'b1;
        shreg_q   <= shifted;
      end
    end
  end

  assign load = frame_done && (!rx_vld_q || rx.rx_rdy);
  assign drop = frame_done && rx_vld_q && !rx.rx_rdy;

  always_ff @(posedge clk_r or posedge rstn_r) begin
    if (rstn_r) begin
      rx_data_q <= '0;
      rx_vld_q  <= 1'b0;
      rx_eot_q  <= 1'b0;
      rx_ovf_q  <= 1'b0;
      rx_err_q  <= 1'b0;
    end else begin
      rx_eot_q <= frame_done;
      rx_ovf_q <= drop;
      rx_err_q <= frame_abort;
      if (load) begin
        rx_data_q <= shifted & len_mask;
        rx_vld_q  <= 1'b1;
      end else if (rx_vld_q && rx.rx_rdy) begin
        rx_vld_q <= 1'b0;
      end
    end
  end

  assign rx.rx_data = rx_data_q;
  assign rx.rx_vld  = rx_vld_q;
  assign rx.rx_eot  = rx_eot_q;
  assign rx.rx_ovf  = rx_ovf_q;
  assign rx.rx_err  = rx_err_q;

endmodule

// File: tb/tb_spi_rx_deser.sv
// Directed bench for spi_rx_deser: a table of single frames over all SPI
// modes plus hand-written overflow, abort, accept-on-completion and reset cases.
`timescale 1ns/1ps
module tb_spi_rx_deser;

  logic       clk_r       = 1'b0;
  logic       rstn_r      = 1'b1;
  logic       cpol        = 1'b0;
  logic       cpoa        = 1'b0;
  logic [4:0] length      = 5'd31;
  logic       spi_bus_clk = 1'b0;
  logic       sdi         = 1'b0;
  logic       cs_n        = 1'b1;

  int total = 0;
  int bad   = 0;
  int eot_cnt = 0;
  int ovf_cnt = 0;
  int err_cnt = 0;

  spi_rx_deser_if #(.SPI_RX_WIDTH(32)) rx_if ();

  spi_rx_deser #(.DLY(1), .SPI_RX_WIDTH(32)) dut (
    .clk_r       (clk_r),
    .rstn_r      (rstn_r),
    .cpol        (cpol),
    .cpoa        (cpoa),
    .length      (length),
    .spi_bus_clk (spi_bus_clk),
    .sdi         (sdi),
    .cs_n        (cs_n),
    .rx          (rx_if.master)
  );

  always #5 clk_r = ~clk_r;

  // Pulse counters: each cycle a pulse is high adds one, so a count also
  // exposes pulses that are too wide.
  always @(posedge clk_r) begin
    #1;
    if (rx_if.rx_eot === 1'b1) eot_cnt++;
    if (rx_if.rx_ovf === 1'b1) ovf_cnt++;
    if (rx_if.rx_err === 1'b1) err_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  typedef struct {
    bit          pol;
    bit          pha;
    logic [4:0]  len;
    logic [31:0] data;
    int          nbits;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk_r);
  endtask

  task automatic clr_cnt();
    eot_cnt = 0;
    ovf_cnt = 0;
    err_cnt = 0;
  endtask

  task automatic start_frame(input bit pol, input bit pha, input logic [4:0] len);
    cpol        = pol;
    cpoa        = pha;
    length      = len;
    spi_bus_clk = pol;
    wait_clks(4);
    cs_n = 1'b0;
    wait_clks(4);
  endtask

  // 10-clk_r SCK period. In phase-1 mode the task returns right at the last
  // sampling edge so the caller can time the output latency from there.
  task automatic send_bits(input logic [31:0] data, input int nbits, input bit pol, input bit pha);
    for (int i = nbits - 1; i >= 0; i--) begin
      if (!pha) begin
        sdi = data[i];
        wait_clks(5);
        spi_bus_clk = ~pol;
        wait_clks(5);
        spi_bus_clk = pol;
      end else begin
        spi_bus_clk = ~pol;
        sdi = data[i];
        wait_clks(5);
        spi_bus_clk = pol;
        if (i > 0) wait_clks(5);
      end
    end
  endtask

  task automatic end_frame();
    wait_clks(5);
    cs_n = 1'b1;
    wait_clks(6);
  endtask

  task automatic accept();
    rx_if.rx_rdy = 1'b1;
    wait_clks(1);
    rx_if.rx_rdy = 1'b0;
  endtask

  initial begin
    rx_if.rx_rdy = 1'b0;
    vecs[0] = '{1'b0, 1'b0, 5'd7,  32'h0000003C, 8,  32'h0000003C};
    vecs[1] = '{1'b0, 1'b1, 5'd7,  32'h0000003C, 8,  32'h0000003C};
    vecs[2] = '{1'b1, 1'b0, 5'd7,  32'h0000003C, 8,  32'h0000003C};
    vecs[3] = '{1'b1, 1'b1, 5'd0,  32'h00000001, 1,  32'h00000001};
    vecs[4] = '{1'b1, 1'b0, 5'd15, 32'h00008001, 16, 32'h00008001};
    vecs[5] = '{1'b0, 1'b1, 5'd31, 32'h80000001, 32, 32'h80000001};

    // Reset state
    wait_clks(3);
    check("rst_vld",  {31'd0, rx_if.rx_vld}, 32'd0);
    check("rst_data", rx_if.rx_data, 32'd0);
    check("rst_eot",  {31'd0, rx_if.rx_eot}, 32'd0);
    check("rst_ovf",  {31'd0, rx_if.rx_ovf}, 32'd0);
    check("rst_err",  {31'd0, rx_if.rx_err}, 32'd0);
    rstn_r = 1'b0;
    wait_clks(3);

    // Mode (1,1), 32 bits, rx_rdy high: latency from last rising SCK edge
    clr_cnt();
    start_frame(1'b1, 1'b1, 5'd31);
    rx_if.rx_rdy = 1'b1;
    send_bits(32'hA5A51234, 32, 1'b1, 1'b1);
    wait_clks(2);
    check("lat_vld_early", {31'd0, rx_if.rx_vld}, 32'd0);
    wait_clks(1);
    check("lat_vld",  {31'd0, rx_if.rx_vld}, 32'd1);
    check("lat_eot",  {31'd0, rx_if.rx_eot}, 32'd1);
    check("lat_data", rx_if.rx_data, 32'hA5A51234);
    wait_clks(1);
    check("lat_vld_taken", {31'd0, rx_if.rx_vld}, 32'd0);
    rx_if.rx_rdy = 1'b0;
    end_frame();
    check("lat_eot_cnt", eot_cnt, 32'd1);

    // Table: single frames across modes and lengths
    for (int i = 0; i < 6; i++) begin
      clr_cnt();
      start_frame(vecs[i].pol, vecs[i].pha, vecs[i].len);
      send_bits(vecs[i].data, vecs[i].nbits, vecs[i].pol, vecs[i].pha);
      end_frame();
      check($sformatf("v%0d_data", i), rx_if.rx_data, vecs[i].exp);
      check($sformatf("v%0d_vld", i), {31'd0, rx_if.rx_vld}, 32'd1);
      check($sformatf("v%0d_eot_cnt", i), eot_cnt, 32'd1);
      check($sformatf("v%0d_ovf_cnt", i), ovf_cnt, 32'd0);
      check($sformatf("v%0d_err_cnt", i), err_cnt, 32'd0);
      accept();
      check($sformatf("v%0d_vld_taken", i), {31'd0, rx_if.rx_vld}, 32'd0);
    end

    // Back-to-back frames with rx_rdy low: second one overflows
    clr_cnt();
    start_frame(1'b0, 1'b0, 5'd31);
    send_bits(32'h11111111, 32, 1'b0, 1'b0);
    send_bits(32'h22222222, 32, 1'b0, 1'b0);
    end_frame();
    check("ovf_data",    rx_if.rx_data, 32'h11111111);
    check("ovf_vld",     {31'd0, rx_if.rx_vld}, 32'd1);
    check("ovf_eot_cnt", eot_cnt, 32'd2);
    check("ovf_ovf_cnt", ovf_cnt, 32'd1);
    accept();
    check("ovf_vld_taken", {31'd0, rx_if.rx_vld}, 32'd0);
    check("ovf_data_hold", rx_if.rx_data, 32'h11111111);

    // Abort after 5 sampled bits, then a clean frame
    clr_cnt();
    start_frame(1'b0, 1'b0, 5'd31);
    send_bits(32'h00000016, 5, 1'b0, 1'b0);
    wait_clks(3);
    cs_n = 1'b1;
    wait_clks(8);
    check("abort_err_cnt", err_cnt, 32'd1);
    check("abort_eot_cnt", eot_cnt, 32'd0);
    check("abort_vld",     {31'd0, rx_if.rx_vld}, 32'd0);
    start_frame(1'b0, 1'b0, 5'd31);
    send_bits(32'hDEADBEEF, 32, 1'b0, 1'b0);
    end_frame();
    check("after_abort_data", rx_if.rx_data, 32'hDEADBEEF);
    check("after_abort_vld",  {31'd0, rx_if.rx_vld}, 32'd1);
    check("after_abort_eot",  eot_cnt, 32'd1);
    check("after_abort_err",  err_cnt, 32'd1);
    accept();

    // rx_rdy high exactly at the completion of frame 2 while frame 1 is held
    clr_cnt();
    start_frame(1'b1, 1'b1, 5'd31);
    send_bits(32'hCAFE0001, 32, 1'b1, 1'b1);
    wait_clks(5);
    check("acc_f1_vld", {31'd0, rx_if.rx_vld}, 32'd1);
    send_bits(32'h12345678, 32, 1'b1, 1'b1);
    wait_clks(2);
    rx_if.rx_rdy = 1'b1;
    wait_clks(1);
    rx_if.rx_rdy = 1'b0;
    check("acc_data", rx_if.rx_data, 32'h12345678);
    check("acc_vld",  {31'd0, rx_if.rx_vld}, 32'd1);
    wait_clks(3);
    check("acc_vld_hold", {31'd0, rx_if.rx_vld}, 32'd1);
    check("acc_ovf_cnt",  ovf_cnt, 32'd0);
    check("acc_eot_cnt",  eot_cnt, 32'd2);
    end_frame();

    // Reset at bit 16 while a word is still valid, then a fresh frame
    clr_cnt();
    start_frame(1'b0, 1'b0, 5'd31);
    send_bits(32'h0000A5A5, 16, 1'b0, 1'b0);
    wait_clks(2);
    rstn_r = 1'b1;
    wait_clks(1);
    check("mid_rst_vld",  {31'd0, rx_if.rx_vld}, 32'd0);
    check("mid_rst_data", rx_if.rx_data, 32'd0);
    cs_n = 1'b1;
    wait_clks(2);
    rstn_r = 1'b0;
    wait_clks(8);
    check("mid_rst_err_cnt", err_cnt, 32'd0);
    check("mid_rst_eot_cnt", eot_cnt, 32'd0);
    check("mid_rst_vld_after", {31'd0, rx_if.rx_vld}, 32'd0);
    start_frame(1'b0, 1'b0, 5'd31);
    send_bits(32'h0000FFFF, 32, 1'b0, 1'b0);
    end_frame();
    check("post_rst_data", rx_if.rx_data, 32'h0000FFFF);
    check("post_rst_vld",  {31'd0, rx_if.rx_vld}, 32'd1);
    check("post_rst_eot",  eot_cnt, 32'd1);
    check("post_rst_err",  err_cnt, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_rx_deser.md
Name: spi_rx_deser

Overview:
- SPI receive deserializer. It sits directly downstream of spi_tx.
- Consumes sdo/spi_bus_clk (driven into sdi/spi_bus_clk here) plus an active-low frame select.
- Samples serial data in the clk_r domain with oversampled, synchronized SPI clock edges.
- Presents completed words on a valid/ready interface to downstream logic.

Parameters:
- DLY, 1: register assignment delay (simulation only).
- SPI_RX_WIDTH, 32: maximum frame length in bits; must be a power of two, ≥4.
- LEN_W, $clog2(SPI_RX_WIDTH): width of the length port.

Ports:
- clk_r  input  1  system clock.
- rstn_r  input  1  reset, asynchronous, active-high.
- cpol  input  1  SPI clock idle polarity.
- cpoa  input  1  SPI clock phase: 0 = sample on leading edge, 1 = sample on trailing edge.
- length  input  LEN_W  frame bit count minus 1.
- spi_bus_clk  input  1  SPI serial clock, asynchronous to clk_r.
- sdi  input  1  serial data, MSB first.
- cs_n  input  1  frame select, active-low, asynchronous.
- rx_data  output  SPI_RX_WIDTH  received word, right-aligned.
- rx_vld  output  1  rx_data valid.
- rx_rdy  input  1  downstream accept.
- rx_eot  output  1  one-cycle pulse at each completed frame.
- rx_ovf  output  1  one-cycle pulse when a completed frame is dropped.
- rx_err  output  1  one-cycle pulse when a frame is aborted by cs_n.

Behaviour:
- Reset: rstn_r high asynchronously clears all state.
  - All outputs reset to 0.
  - FSM goes to IDLE; synchronizers reset as follows: sck to cpol-independent 0, cs_n to 1.
- Synchronization:
  - spi_bus_clk, sdi and cs_n each pass through a 2-FF synchronizer (s1, s2), plus a third stage s3 for edge detection.
  - Edge detect is combinational: s2 != s3 on the clock line.
  - Supported rate: spi_bus_clk half-period ≥ 3 clk_r periods.
- Sampling edge: rising when (cpol ^ cpoa) == 0, falling otherwise. Mode (1,1) therefore samples on rising.
- cpol, cpoa and length are latched at the IDLE->SHIFT transition and held for the frame. Changes mid-frame have no effect.
- FSM state IDLE:
  - bit_cnt = 0, shift register = 0.
  - When synced cs_n == 0, go to SHIFT (latch config).
  - SCK edges while cs_n high are ignored.
- FSM state SHIFT, on each sampling edge:
  - shreg <= {shreg[W-2:0], sdi_s2}; bit_cnt++.
  - When bit_cnt == latched length at a sampling edge, the frame completes:
    - The value {shreg[W-2:0], sdi_s2}, masked to length+1 bits (upper bits 0), is offered to the output buffer.
    - bit_cnt and shreg clear; FSM stays in SHIFT for a back-to-back frame if cs_n is still low.
    - rx_eot pulses 1 cycle.
  - Synced cs_n == 1 in SHIFT:
    - If bit_cnt != 0: rx_err pulses 1 cycle and the partial data is discarded.
    - If bit_cnt == 0: silent.
    - Either way, go to IDLE.
- Output buffer, a single register:
  - On frame completion, if rx_vld == 0, or rx_vld && rx_rdy in the same cycle: load rx_data; rx_vld = 1 next cycle.
  - If rx_vld && !rx_rdy: the new frame is dropped, rx_ovf pulses, and the old rx_data/rx_vld are held.
  - rx_vld && rx_rdy with no completion: rx_vld clears next cycle; rx_data holds its last value.
  - rx_data is stable while rx_vld is high and rx_rdy is low.
- Latency, with a pin edge set up before clk_r edge k:
  - s2 updates at k+1.
  - shreg/buffer load at k+2.
  - rx_vld and rx_eot are high after k+2 (visible cycle k+2..k+3).
  - Total: 3 clk_r edges from pin to rx_vld.
- Reset mid-frame: immediate abort. No rx_err, rx_vld, or rx_eot is generated.
- length = 0: 1-bit frames are supported; rx_data = {0..., bit}.
- Length width: LEN_W bits, so the maximum frame length is SPI_RX_WIDTH. No clamping is needed.

Test Plan:
1. Mode (1,1), length=31, cs_n low, sdi serializes 0xA5A51234 MSB first with a 10-clk_r SCK period, rx_rdy=1 -> one rx_eot, then rx_vld with rx_data=0xA5A51234, 3 clk_r edges after the last rising SCK edge.
2. Mode (0,0), length=7, byte 0x3C -> rx_data=0x0000003C. Repeat with modes (0,1) and (1,0); the same data is required in each case.
3. Two back-to-back 32-bit frames, 0x11111111 then 0x22222222, with rx_rdy held 0 -> rx_data stays 0x11111111, rx_vld=1, one rx_ovf pulse at the second completion. Raising rx_rdy then clears rx_vld.
4. cs_n released after 5 sampled bits -> rx_err 1-cycle pulse, no rx_vld/rx_eot. The next full frame 0xDEADBEEF is received correctly.
5. rx_rdy=1 coinciding with completion of frame 2 while frame 1 is valid -> frame 1 accepted, rx_data=frame 2, rx_vld stays 1, no rx_ovf.
6. rstn_r pulsed high at bit 16 of a frame -> all outputs 0, FSM in IDLE. After release, a fresh frame 0x0000FFFF (length=31) is received intact.
